store_datapath: RTL and testbench
=================================

# store_datapath

Output-side counterpart of the SHAKE load datapath. Captures the rate portion of the Keccak state after each permutation and serializes it into `w`-bit words on a valid/ready stream. Counts down the requested output length and requests further squeeze permutations until the length is exhausted. Sits between the permutation core and the core's output port, and drives the last-word and partial-word information for the final word.

## Interface

Parameters:
- `w`, 64 (from keccak_pkg): output word width in bits.
- `RATE_SHAKE128`, 1344 (from keccak_pkg): width of the parallel rate input.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse; latches `output_size` and `operation_mode`. Honoured only in IDLE.
- `output_size` in 32: requested output length in bits. Only [27:0] are meaningful. Must be a multiple of 8.
- `operation_mode` in 2: SHAKE256_MODE_VEC gives 17 words per block; any other value gives 21.
- `rate_output` in RATE_SHAKE128: rate lanes of the permuted state; word 0 is at bits [63:0].
- `block_valid` in 1: `rate_output` is valid this cycle. Honoured only in WAIT_BLOCK.
- `squeeze_request` out 1: requests a permuted state from the core.
- `data_out` out w: output word, big-endian byte order.
- `data_out_valid` out 1: `data_out` holds a word.
- `data_out_ready` in 1: the consumer accepts the word.
- `data_out_last` out 1: the current word is the final word.
- `last_word_bytes` out 4: number of valid bytes in the current word (1..8).
- `done` out 1: one-cycle pulse when the operation completes.
- `busy` out 1: high in every state except IDLE.

## Operation

- **FSM states:** IDLE, WAIT_BLOCK, DRAIN, DONE. The state enum lives in keccak_pkg.
- **IDLE:**
  - `start` with `output_size` != 0 latches the size into a 32-bit remaining counter and latches the mode, then goes to WAIT_BLOCK.
  - `start` with `output_size` == 0 goes to DONE. No word is emitted.
- **WAIT_BLOCK:**
  - `squeeze_request` = 1.
  - On `block_valid`: parallel-load the PISO buffer with `rate_output`, load the block word counter with 17 or 21, then go to DRAIN.
- **DRAIN:**
  - `data_out_valid` = 1. `data_out` is buffer word 0 with its bytes swapped (EndianSwitcher).
  - A transfer is `data_out_valid && data_out_ready`. On a transfer:
    - shift the buffer by one word;
    - decrement the word counter;
    - subtract 64 from the remaining counter, saturating at 0.
- **Last word:** `data_out_last` = 1 when remaining <= 64.
  - `last_word_bytes` = remaining[5:3], or 8 when remaining[5:3] == 0.
  - On any non-last word, `last_word_bytes` = 8.
- **Transitions out of DRAIN, on a transfer:**
  - Last word: go to DONE. This takes priority over the block-boundary rule.
  - Word counter reaches 0 with size remaining: go to WAIT_BLOCK.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Ignored inputs:** `start` outside IDLE; `block_valid` outside WAIT_BLOCK.
- **Reset:** returns to IDLE from any state, including mid-DRAIN. Buffer, counters and latched mode clear. No partial stream is resumed.

## Timing

- **Reset values:** every output is 0.
- **Start to request:** `start` at cycle N gives `squeeze_request` = 1 from cycle N+1.
- **Block to first word:** `block_valid` at cycle M gives `data_out_valid` = 1 at M+1, and `squeeze_request` = 0 at M+1.
- **Throughput:** one word per cycle while `data_out_ready` is held high.
- **Back-pressure:** when `data_out_ready` = 0, `data_out`, `data_out_last` and `last_word_bytes` hold stable.
- **Completion:** the last transfer at cycle K gives `done` = 1 at K+1 and IDLE at K+2. `busy` falls at K+2.
- **Block boundary:** the final transfer of a block at cycle K gives `squeeze_request` = 1 at K+1. `data_out_valid` = 0 until the next block loads.

## Configuration

- **`STORE_BYTE_MASK_EN` defined:** bytes beyond `last_word_bytes` on the last word are forced to 0. Because bytes are big-endian, the valid bytes occupy `data_out[63 -: 8*last_word_bytes]`.
- **`STORE_BYTE_MASK_EN` undefined:** the last word carries raw state bytes. The consumer relies on `last_word_bytes` alone.

## Structure

- **keccak_pkg supplies:** `w`, `RATE_SHAKE128`, SHAKE256_MODE_VEC, SHAKE128_MODE_VEC and EndianSwitcher.
- **Added to keccak_pkg:** `store_state_t`, and the localparams for 17 and 21 words per block.
- **Sub-module `piso_buffer`:** parameters WIDTH and DEPTH; inputs `load` and `shift`; output `data_out` is word 0. It is the mirror of `sipo_buffer`.
- **In store_datapath:** the remaining and word counters stay inline; `regn` is reused for the mode and size latches.

## Test plan

- **SHAKE128, 256 bits, ready tied high:** 4 words, `data_out_last` on word 4, `last_word_bytes` = 8, one `squeeze_request` phase, `done` one cycle after word 4.
- **SHAKE256, 1088 bits:** exactly 17 words, no second `squeeze_request`. Then 1152 bits: 17 words, a second request, 1 word with `last_word_bytes` = 8.
- **SHAKE128, 200 bits:** 4 words; the last has `last_word_bytes` = 1. With `STORE_BYTE_MASK_EN`, `data_out[55:0]` = 0.
- **Random `data_out_ready` back-pressure, 1344+128 bits SHAKE128:** 23 words, in order, stable while stalled; second block requested after word 21.
- **`output_size` = 0:** `done` pulses at N+1, no `squeeze_request`, no `data_out_valid`.
- **`rst` asserted during DRAIN word 5:** all outputs 0 next cycle, IDLE. A new `start` then completes normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, mode encodings, store FSM states and byte-order helper.
package keccak_pkg;
    localparam int w = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;
    localparam logic [4:0] WORDS_SHAKE128 = 5'd21;
    localparam logic [4:0] WORDS_SHAKE256 = 5'd17;

    typedef enum logic [1:0] {IDLE, WAIT_BLOCK, DRAIN, DONE} store_state_t;

    function automatic logic [w-1:0] EndianSwitcher(input logic [w-1:0] d);
        for (int i = 0; i < w / 8; i++) EndianSwitcher[8*i +: 8] = d[w-8-8*i +: 8];
    endfunction
endpackage

// File: rtl/piso_buffer.sv
// piso_buffer: parallel-load, word-shift buffer presenting word 0 (mirror of sipo_buffer).
module piso_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   shift,
    input  logic [WIDTH*DEPTH-1:0] data_in,
    output logic [WIDTH-1:0]       data_out
);
    logic [WIDTH*DEPTH-1:0] words;
    always_ff @(posedge clk)
        if (rst) words <= '0;
        else if (load) words <= data_in;
        else if (shift) words <= words >> WIDTH;
    assign data_out = words[WIDTH-1:0];
endmodule

// File: rtl/regn.sv
// regn: enabled register with synchronous active-high reset.
module regn #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/store_datapath.sv
// store_datapath: serializes squeezed rate blocks into w-bit big-endian words.
// Define STORE_BYTE_MASK_EN to zero the invalid trailing bytes of the last word.
module store_datapath
    import keccak_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              output_size,
    input  logic [1:0]               operation_mode,
    input  logic [RATE_SHAKE128-1:0] rate_output,
    input  logic                     block_valid,
    output logic                     squeeze_request,
    output logic [w-1:0]             data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic                     data_out_last,
    output logic [3:0]               last_word_bytes,
    output logic                     done,
    output logic                     busy
);
    store_state_t state, state_next;
    logic [31:0] remaining;
    logic [4:0] word_cnt;
    logic [1:0] mode;
    logic [w-1:0] word0, raw;
    logic idle_start, load, xfer;

    assign idle_start = state == IDLE && start;
    assign load = state == WAIT_BLOCK && block_valid;
    assign xfer = data_out_valid && data_out_ready;

    regn #(.WIDTH(2)) mode_reg (
        .clk(clk), .rst(rst), .en(idle_start), .d(operation_mode), .q(mode)
    );

    piso_buffer #(.WIDTH(w), .DEPTH(RATE_SHAKE128 / w)) buffer (
        .clk(clk), .rst(rst), .load(load), .shift(xfer), .data_in(rate_output), .data_out(word0)
    );

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            remaining <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_next;
            if (idle_start) remaining <= output_size;
            else if (xfer) remaining <= remaining > 32'd64 ? remaining - 32'd64 : '0;
            if (load) word_cnt <= mode == SHAKE256_MODE_VEC ? WORDS_SHAKE256 : WORDS_SHAKE128;
            else if (xfer) word_cnt <= word_cnt - 5'd1;
        end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = output_size == '0 ? DONE : WAIT_BLOCK;
            WAIT_BLOCK: if (block_valid) state_next = DRAIN;
            DRAIN:      if (xfer) state_next = data_out_last ? DONE : word_cnt == 5'd1 ? WAIT_BLOCK : DRAIN;
            default:    state_next = IDLE;
        endcase
    end

    assign squeeze_request = state == WAIT_BLOCK;
    assign data_out_valid = state == DRAIN;
    assign done = state == DONE;
    assign busy = state != IDLE;
    assign data_out_last = data_out_valid && remaining <= 32'd64;
    assign last_word_bytes = !data_out_valid ? 4'd0 :
                             data_out_last && remaining[5:3] != 3'd0 ? {1'b0, remaining[5:3]} : 4'd8;
    assign raw = data_out_valid ? EndianSwitcher(word0) : '0;
`ifdef STORE_BYTE_MASK_EN
    // Big-endian output: valid bytes are the top last_word_bytes bytes.
    assign data_out = data_out_last ? raw & ({w{1'b1}} << (7'd64 - {last_word_bytes, 3'b000})) : raw;
`else
    assign data_out = raw;
`endif
endmodule

// File: tb/tb_store_datapath.sv
// tb_store_datapath: scoreboard bench for store_datapath with a simple permutation-core model.
module tb_store_datapath;
    import keccak_pkg::*;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
        logic [3:0]  nb;
    } exp_t;

    logic clk = 0, rst = 1, start = 0, block_valid = 0, data_out_ready = 1;
    logic [31:0] output_size = '0;
    logic [1:0] operation_mode = '0;
    logic [RATE_SHAKE128-1:0] rate_output = '0;
    logic squeeze_request, data_out_valid, data_out_last, done, busy;
    logic [w-1:0] data_out;
    logic [3:0] last_word_bytes;

    exp_t exp_q[$];
    int total = 0, bad = 0, xfers = 0, rises = 0, dones = 0, cyc = 0, last_cyc = 0, blk = 0;
    bit rand_ready = 0, last_pending = 0;

    always #5 clk = ~clk;

    store_datapath dut (
        .clk(clk), .rst(rst), .start(start), .output_size(output_size),
        .operation_mode(operation_mode), .rate_output(rate_output), .block_valid(block_valid),
        .squeeze_request(squeeze_request), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last),
        .last_word_bytes(last_word_bytes), .done(done), .busy(busy)
    );

    function automatic logic [63:0] pattern(input int b, input int i);
        return {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'(b), 8'(i)};
    endfunction

    function automatic logic [63:0] swap(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
        return r;
    endfunction

    function automatic logic [RATE_SHAKE128-1:0] make_block(input int b);
        logic [RATE_SHAKE128-1:0] r;
        for (int i = 0; i < 21; i++) r[64*i +: 64] = pattern(b, i);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_expected(input int size, input logic [1:0] mode);
        int wpb, n, rem;
        exp_t e;
        wpb = mode == SHAKE256_MODE_VEC ? 17 : 21;
        n = (size + 63) / 64;
        for (int k = 0; k < n; k++) begin
            rem = size - 64 * k;
            e.last = k == n - 1;
            e.nb = e.last && (rem / 8) % 8 != 0 ? 4'((rem / 8) % 8) : 4'd8;
            e.d = swap(pattern(k / wpb, k % wpb));
`ifdef STORE_BYTE_MASK_EN
            if (e.last) e.d = e.d & ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * e.nb));
`endif
            exp_q.push_back(e);
        end
    endtask

    // Core model: answers a squeeze request two cycles later; also drives ready.
    initial begin
        int delay = 0;
        forever begin
            @(negedge clk); #1;
            block_valid = 0;
            data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (squeeze_request && !rst) begin
                delay++;
                if (delay == 2) begin
                    rate_output = make_block(blk);
                    block_valid = 1;
                    blk++;
                    delay = 0;
                end
            end else delay = 0;
        end
    end

    // Monitor: pops the scoreboard on every accepted word and checks hold under stall.
    initial begin
        logic sq_prev = 0, stalled = 0;
        exp_t prev, cur, e;
        forever begin
            @(negedge clk); #3;
            cyc++;
            if (squeeze_request && !sq_prev) rises++;
            sq_prev = squeeze_request;
            if (done) begin
                dones++;
                if (last_pending) check("done_timing", 128'(cyc), 128'(last_cyc + 1));
                last_pending = 0;
            end
            if (data_out_valid) begin
                cur = {data_out, data_out_last, last_word_bytes};
                if (stalled) check("stall_hold", cur, prev);
                stalled = !data_out_ready;
                prev = cur;
                if (data_out_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) check("unexpected_word", cur, 128'hx);
                    else begin
                        e = exp_q.pop_front();
                        check("word", cur, e);
                    end
                    if (data_out_last) begin
                        last_pending = 1;
                        last_cyc = cyc;
                    end
                end
            end else stalled = 0;
        end
    end

    task automatic run_op(input int size, input logic [1:0] mode, input bit rnd, input int phases);
        int r0, d0, x0, t;
        push_expected(size, mode);
        blk = 0;
        rand_ready = rnd;
        r0 = rises; d0 = dones; x0 = xfers;
        @(negedge clk); #1;
        output_size = size;
        operation_mode = mode;
        start = 1;
        @(negedge clk); #4;
        start = 0;
        check("start_request", squeeze_request, size != 0);
        check("start_done", done, size == 0);
        t = 0;
        while (dones == d0 && t < 3000) begin
            @(negedge clk); #4;
            t++;
        end
        if (dones == d0) check("done_timeout", 0, 1);
        check("word_count", xfers - x0, (size + 63) / 64);
        check("request_phases", rises - r0, phases);
        check("queue_empty", exp_q.size(), 0);
        @(negedge clk); #4;
        check("idle_after_done", {busy, done, squeeze_request, data_out_valid}, 4'b0);
        rand_ready = 0;
    endtask

    initial begin
        int x0, t;
        repeat (3) @(negedge clk);
        #4;
        check("rst_outputs", {squeeze_request, data_out_valid, data_out_last, done, busy}, 5'b0);
        check("rst_data", {data_out, last_word_bytes}, 68'h0);
        @(negedge clk); #1;
        rst = 0;

        run_op(256, SHAKE128_MODE_VEC, 0, 1);
        run_op(1088, SHAKE256_MODE_VEC, 0, 1);
        run_op(1152, SHAKE256_MODE_VEC, 0, 2);
        run_op(200, SHAKE128_MODE_VEC, 0, 1);
        run_op(1472, SHAKE128_MODE_VEC, 1, 2);
        run_op(0, SHAKE128_MODE_VEC, 0, 0);

        // Reset while the fifth word of a block is on the bus.
        push_expected(1344, SHAKE128_MODE_VEC);
        blk = 0;
        x0 = xfers;
        @(negedge clk); #1;
        output_size = 1344;
        operation_mode = SHAKE128_MODE_VEC;
        start = 1;
        @(negedge clk); #1;
        start = 0;
        t = 0;
        while (xfers < x0 + 5 && t < 200) begin
            @(negedge clk); #4;
            t++;
        end
        if (xfers < x0 + 5) check("drain_timeout", 0, 1);
        rst = 1;
        @(negedge clk); #4;
        check("midrst_outputs", {squeeze_request, data_out_valid, data_out_last, done, busy}, 5'b0);
        check("midrst_data", {data_out, last_word_bytes}, 68'h0);
        rst = 0;
        exp_q.delete();
        last_pending = 0;
        run_op(256, SHAKE128_MODE_VEC, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
